// File: rtl/gps_adc_frontend.sv
`default_nettype none
// ============================================================================
// Module   : gps_adc_frontend
// Purpose  : 2-bit I/Q ADC synchroniser, signed 3-bit mapper, window stats
// Revision : 1.0
// ============================================================================
module gps_adc_frontend #(
  parameter int WIN_LOG2 = 10
) (
  input  logic                mclk,
  input  logic                mclr,
  input  logic                fe_en,
  input  logic                fmt_sel,
  input  logic [1:0]          adc2bit_i,
  input  logic [1:0]          adc2bit_q,
  output logic [2:0]          samp_i,
  output logic [2:0]          samp_q,
  output logic                samp_valid,
  output logic [WIN_LOG2:0]   mag_cnt_i,
  output logic [WIN_LOG2:0]   mag_cnt_q,
  output logic [WIN_LOG2:0]   sgn_cnt_i,
  output logic [WIN_LOG2:0]   sgn_cnt_q,
  output logic                stat_valid
);

  localparam logic [WIN_LOG2-1:0] WC_ONE = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2:0]   ACC_ZERO = '0;

  logic [1:0] sync1_i, sync2_i, sync1_q, sync2_q;
  logic       v1, v2;

  logic [WIN_LOG2-1:0] wc;
  logic [WIN_LOG2:0]   acc_mag_i, acc_mag_q, acc_sgn_i, acc_sgn_q;

  logic flag_mag_i, flag_mag_q, flag_sgn_i, flag_sgn_q;
  logic [WIN_LOG2:0] sum_mag_i, sum_mag_q, sum_sgn_i, sum_sgn_q;

  // Sign bit is code[1] in both formats; only the magnitude bit differs.
  // Result encodes +1=001, +3=011, -1=111, -3=101.
  function automatic logic [2:0] map_code(input logic [1:0] code, input logic twos);
    logic mag;
    mag = twos ? (code[1] ^ code[0]) : code[0];
    return {code[1], code[1] ^ mag, 1'b1};
  endfunction

  always_ff @(posedge mclk) begin
    if (mclr) begin
      sync1_i    <= '0;
      sync2_i    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      samp_i     <= '0;
      samp_q     <= '0;
      samp_valid <= 1'b0;
    end else begin
      sync1_i    <= adc2bit_i;
      sync2_i    <= sync1_i;
      sync1_q    <= adc2bit_q;
      sync2_q    <= sync1_q;
      v1         <= fe_en;
      v2         <= v1;
      samp_valid <= v2;
      if (v2) begin
        samp_i <= map_code(sync2_i, fmt_sel);
        samp_q <= map_code(sync2_q, fmt_sel);
      end else begin
        samp_i <= '0;
        samp_q <= '0;
      end
    end
  end

  // Flags come from the mapped samples so a format change mid-window is
  // counted with the format each sample was actually mapped under.
  always_comb begin
    flag_mag_i = samp_i[2] ^ samp_i[1];
    flag_mag_q = samp_q[2] ^ samp_q[1];
    flag_sgn_i = samp_i[2];
    flag_sgn_q = samp_q[2];
    sum_mag_i  = acc_mag_i + {{WIN_LOG2{1'b0}}, flag_mag_i};
    sum_mag_q  = acc_mag_q + {{WIN_LOG2{1'b0}}, flag_mag_q};
    sum_sgn_i  = acc_sgn_i + {{WIN_LOG2{1'b0}}, flag_sgn_i};
    sum_sgn_q  = acc_sgn_q + {{WIN_LOG2{1'b0}}, flag_sgn_q};
  end

  always_ff @(posedge mclk) begin
    if (mclr) begin
      wc         <= '0;
      acc_mag_i  <= ACC_ZERO;
      acc_mag_q  <= ACC_ZERO;
      acc_sgn_i  <= ACC_ZERO;
      acc_sgn_q  <= ACC_ZERO;
      mag_cnt_i  <= ACC_ZERO;
      mag_cnt_q  <= ACC_ZERO;
      sgn_cnt_i  <= ACC_ZERO;
      sgn_cnt_q  <= ACC_ZERO;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (samp_valid) begin
        if (&wc) begin
          mag_cnt_i  <= sum_mag_i;
          mag_cnt_q  <= sum_mag_q;
          sgn_cnt_i  <= sum_sgn_i;
          sgn_cnt_q  <= sum_sgn_q;
          stat_valid <= 1'b1;
          wc         <= '0;
          acc_mag_i  <= ACC_ZERO;
          acc_mag_q  <= ACC_ZERO;
          acc_sgn_i  <= ACC_ZERO;
          acc_sgn_q  <= ACC_ZERO;
        end else begin
          wc        <= wc + WC_ONE;
          acc_mag_i <= sum_mag_i;
          acc_mag_q <= sum_mag_q;
          acc_sgn_i <= sum_sgn_i;
          acc_sgn_q <= sum_sgn_q;
        end
      end else begin
        // A gap in valid samples throws away the partial window.
        wc        <= '0;
        acc_mag_i <= ACC_ZERO;
        acc_mag_q <= ACC_ZERO;
        acc_sgn_i <= ACC_ZERO;
        acc_sgn_q <= ACC_ZERO;
      end
    end
  end

endmodule
`default_nettype wire
